// File: rtl/cam_pkg.sv
// Shared types and defaults for the CMOS frame-capture path.
package cam_pkg;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_SOF, CAPTURE, DONE} cap_state_e;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic    sof;
    logic    eol;
    rgb565_t data;
  } pix_ent_t;

  localparam int DEF_HOR_NUM = 512;
  localparam int DEF_VER_NUM = 8;
endpackage

// File: rtl/pix_fifo2.sv
// Two-entry pixel buffer; a push into a full buffer survives only if a pop
// happens in the same cycle, otherwise it is dropped and flagged.
module pix_fifo2
  import cam_pkg::*;
(
  input  logic     cmos_pclk,
  input  logic     rst,
  input  logic     push,
  input  pix_ent_t din,
  input  logic     pop,
  output pix_ent_t dout,
  output logic     empty,
  output logic     drop
);
  pix_ent_t   ent0, ent1;
  logic [1:0] cnt;
  logic       full, do_pop;

  assign full   = (cnt == 2'd2);
  assign empty  = (cnt == 2'd0);
  assign do_pop = pop & ~empty;
  assign drop   = push & full & ~do_pop;
  assign dout   = ent0;

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= din;
          else if (cnt == 2'd1) ent1 <= din;
          if (!full) cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // head leaves, new entry lands behind whatever remains
          if (cnt == 2'd1) ent0 <= din;
          else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/cmos_capture_ctrl.sv
// Captures exactly one camera frame on request and streams it as RGB565
// pixels with start-of-frame / end-of-line tags.
module cmos_capture_ctrl
  import cam_pkg::*;
#(
  parameter int HOR_NUM = DEF_HOR_NUM,
  parameter int VER_NUM = DEF_VER_NUM,
  parameter int CNT_W   = 16
) (
  input  logic             cmos_pclk,
  input  logic             rst,
  input  logic             cap_start,
  output logic             cap_busy,
  output logic             cap_done,
  output logic             cap_err,
  input  logic [7:0]       cmos_data,
  input  logic             cmos_href,
  input  logic             cmos_vsyn,
  output logic [15:0]      pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic [CNT_W-1:0] line_cnt
);
  cap_state_e       state, state_nxt;
  logic [7:0]       cmos_data_q, hi_byte;
  logic             href_q, href_qq, vsyn_q, vsyn_qq;
  logic             href_fall, vsyn_fall, vsyn_rise;
  logic             in_cap, accept, lines_full;
  logic             tog, sof_pend, push, drop, fifo_empty, line_err;
  logic [CNT_W-1:0] pix_cnt;
  pix_ent_t         push_ent, head;

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      cmos_data_q <= 8'd0;
      href_q      <= 1'b0;
      href_qq     <= 1'b0;
      vsyn_q      <= 1'b0;
      vsyn_qq     <= 1'b0;
    end else begin
      cmos_data_q <= cmos_data;
      href_q      <= cmos_href;
      href_qq     <= href_q;
      vsyn_q      <= cmos_vsyn;
      vsyn_qq     <= vsyn_q;
    end
  end

  assign href_fall  = href_qq & ~href_q;
  assign vsyn_fall  = vsyn_qq & ~vsyn_q;
  assign vsyn_rise  = vsyn_q & ~vsyn_qq;
  assign lines_full = (line_cnt == CNT_W'(VER_NUM));

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ARM waits for blanking first so a mid-frame request never grabs a partial frame
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (cap_start) state_nxt = ARM;
      ARM:      if (vsyn_q) state_nxt = WAIT_SOF;
      WAIT_SOF: if (vsyn_fall) state_nxt = CAPTURE;
      CAPTURE:  if (lines_full || vsyn_rise) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_busy = (state != IDLE);
    cap_done = (state == DONE);
    in_cap   = (state == CAPTURE);
  end

  assign accept   = (state == IDLE) & cap_start;
  assign push     = in_cap & href_q & tog;
  assign line_err = in_cap & href_fall & ((pix_cnt != CNT_W'(HOR_NUM)) | tog);
  assign push_ent = '{sof:  sof_pend,
                      eol:  (pix_cnt == CNT_W'(HOR_NUM - 1)),
                      data: {hi_byte, cmos_data_q}};

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      tog      <= 1'b0;
      hi_byte  <= 8'd0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      cap_err  <= 1'b0;
      sof_pend <= 1'b0;
    end else begin
      // toggle idles at 0 whenever href is low, so every line starts on a high byte
      if (in_cap && href_q) begin
        tog <= ~tog;
        if (!tog) hi_byte <= cmos_data_q;
      end else begin
        tog <= 1'b0;
      end

      if (!in_cap || href_fall) pix_cnt <= '0;
      else if (push && pix_cnt != '1) pix_cnt <= pix_cnt + CNT_W'(1);

      if (accept) line_cnt <= '0;
      else if (in_cap && href_fall) line_cnt <= line_cnt + CNT_W'(1);

      if (accept) cap_err <= 1'b0;
      else if (drop || line_err || (in_cap && vsyn_rise && !lines_full)) cap_err <= 1'b1;

      if (state == WAIT_SOF && vsyn_fall) sof_pend <= 1'b1;
      else if (push) sof_pend <= 1'b0;
    end
  end

  pix_fifo2 u_fifo (
    .cmos_pclk (cmos_pclk),
    .rst       (rst),
    .push      (push),
    .din       (push_ent),
    .pop       (pix_valid & pix_ready),
    .dout      (head),
    .empty     (fifo_empty),
    .drop      (drop)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_data  = head.data;
  assign pix_sof   = head.sof;
  assign pix_eol   = head.eol;
endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Directed frame scenarios with random data/ready, checked against a
// pixel-queue reference model of the capture stream.
module tb_cmos_capture_ctrl;
  localparam int HOR = 512;
  localparam int VER = 8;
  localparam int CW  = 16;

  logic          cmos_pclk = 1'b0;
  logic          rst, cap_start, cmos_href, cmos_vsyn, pix_ready;
  logic [7:0]    cmos_data;
  logic          cap_busy, cap_done, cap_err, pix_valid, pix_sof, pix_eol;
  logic [15:0]   pix_data;
  logic [CW-1:0] line_cnt;

  always #5 cmos_pclk = ~cmos_pclk;

  cmos_capture_ctrl #(.HOR_NUM(HOR), .VER_NUM(VER), .CNT_W(CW)) dut (
    .cmos_pclk (cmos_pclk),
    .rst       (rst),
    .cap_start (cap_start),
    .cap_busy  (cap_busy),
    .cap_done  (cap_done),
    .cap_err   (cap_err),
    .cmos_data (cmos_data),
    .cmos_href (cmos_href),
    .cmos_vsyn (cmos_vsyn),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .line_cnt  (line_cnt)
  );

  int          n_chk, n_fail;
  logic [17:0] mq [$];
  logic        pend_v;
  logic [17:0] pend_pix;
  int          m_drop;
  bit          m_cap, m_sof, g_rnd_data, g_rnd_rdy;
  int          rlo [VER];
  int          rlen[VER];
  int          spl, spbytes, rst_line, rst_at;
  int          rx_cnt, rx_sof, rx_eol, done_cnt;
  logic [15:0] rx_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"},  32'(cap_busy),  0);
    chk({tag, "_done"},  32'(cap_done),  0);
    chk({tag, "_err"},   32'(cap_err),   0);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_data"},  32'(pix_data),  0);
    chk({tag, "_sof"},   32'(pix_sof),   0);
    chk({tag, "_eol"},   32'(pix_eol),   0);
    chk({tag, "_lines"}, 32'(line_cnt),  0);
  endtask

  // One pixel clock: observe at negedge, drive, then advance the model at posedge.
  // prod marks a pixel whose second byte is on the pins this cycle.
  task automatic tick(input logic [7:0] d, input logic h, input logic v, input logic st,
                      input logic fl, input logic prod, input logic [17:0] pix);
    logic rdy, pop, full;
    @(negedge cmos_pclk);
    chk("pix_valid", 32'(pix_valid), 32'(mq.size() > 0));
    if (mq.size() > 0 && pix_valid)
      chk("pix_head", {14'd0, pix_sof, pix_eol, pix_data}, {14'd0, mq[0]});
    rdy = fl ? 1'b0 : (g_rnd_rdy ? ($urandom_range(0, 7) != 0) : 1'b1);
    if (pix_valid && rdy) begin
      if (rx_cnt == 0) rx_first = pix_data;
      rx_cnt++;
      rx_sof += int'(pix_sof);
      rx_eol += int'(pix_eol);
    end
    if (cap_done) begin
      done_cnt++;
      chk("busy_in_done", 32'(cap_busy), 1);
    end
    cmos_data = d; cmos_href = h; cmos_vsyn = v; cap_start = st; pix_ready = rdy;
    @(posedge cmos_pclk);
    full = (mq.size() == 2);
    pop  = (mq.size() > 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (pend_v) begin
      if (full && !pop) m_drop++;
      else mq.push_back(pend_pix);
    end
    pend_v   = prod;
    pend_pix = pix;
  endtask

  task automatic idle(input logic v);
    tick(8'h00, 1'b0, v, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic drive_line(input int l);
    int nb;
    logic [15:0] px;
    logic [7:0] by;
    logic prod, fl, eol;
    nb = (l == spl) ? spbytes : 2 * HOR;
    px = '0;
    for (int b = 0; b < nb; b++) begin
      if (b % 2 == 0)
        px = g_rnd_data ? 16'($urandom) : {8'(8'h80 + 4 * l + b / 512), 8'(b / 2)};
      by   = (b % 2 == 0) ? px[15:8] : px[7:0];
      prod = (b % 2 == 1) && m_cap && (l < VER);
      eol  = (b / 2 == HOR - 1);
      fl   = (b >= rlo[l]) && (b < rlo[l] + rlen[l]);
      tick(by, 1'b1, 1'b0, 1'b0, fl, prod, {m_sof && prod, eol, px});
      if (prod) m_sof = 1'b0;
      if (l == rst_line && b == rst_at) begin
        #2 rst = 1'b1;
        #1 chk_rst("midrst");
        mq.delete();
        pend_v = 1'b0;
        m_cap  = 1'b0;
      end
    end
    if (rst === 1'b1) @(negedge cmos_pclk) rst = 1'b0;
    for (int i = 0; i < 8; i++) idle(1'b0);
  endtask

  task automatic frame(input int nl, input bit cap);
    for (int i = 0; i < 6; i++) idle(1'b1);
    m_cap = cap;
    m_sof = cap;
    for (int i = 0; i < 4; i++) idle(1'b0);
    for (int l = 0; l < nl; l++) begin
      drive_line(l);
      if (l == spl) begin
        chk("line_err_mid", 32'(cap_err), 1);
        chk("busy_mid", 32'(cap_busy), 1);
      end
      if (l == 1 && rlen[1] > 0) chk("bp_noloss_err", 32'(cap_err), 0);
    end
    m_cap = 1'b0;
  endtask

  task automatic start();
    rx_cnt = 0; rx_sof = 0; rx_eol = 0; done_cnt = 0; m_drop = 0;
    tick(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1'b0);
    chk("busy_after_start", 32'(cap_busy), 1);
    chk("err_cleared", 32'(cap_err), 0);
  endtask

  task automatic endf(input int erx, input int eeol, input int elines, input int eerr, input int edone);
    for (int i = 0; i < 6; i++) idle(1'b1);
    for (int i = 0; i < 4; i++) idle(1'b0);
    if (erx >= 0)  chk("rx_cnt", rx_cnt, erx);
    if (eeol >= 0) chk("rx_eol", rx_eol, eeol);
    chk("line_cnt", 32'(line_cnt), elines);
    chk("cap_err", 32'(cap_err), eerr);
    chk("done_cnt", done_cnt, edone);
    chk("busy_end", 32'(cap_busy), 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; cap_start = 1'b0; cmos_data = 8'h00; cmos_href = 1'b0;
    cmos_vsyn = 1'b0; pix_ready = 1'b1;
    pend_v = 1'b0; pend_pix = '0; m_cap = 1'b0; m_sof = 1'b0; m_drop = 0;
    g_rnd_data = 1'b0; g_rnd_rdy = 1'b0;
    spl = -1; spbytes = 0; rst_line = -1; rst_at = -1;
    rx_cnt = 0; rx_sof = 0; rx_eol = 0; done_cnt = 0; rx_first = '0;
    for (int i = 0; i < VER; i++) begin rlo[i] = 0; rlen[i] = 0; end
    repeat (3) @(posedge cmos_pclk);
    #1 chk_rst("por");
    @(negedge cmos_pclk) rst = 1'b0;

    // nominal generator frame
    start(); frame(8, 1'b1);
    endf(4096, 8, 8, 0, 1);
    chk("nom_first", 32'(rx_first), 32'h8000);
    chk("nom_sof", rx_sof, 1);

    // line 3 one pixel short
    spl = 3; spbytes = 2 * HOR - 2;
    start(); frame(8, 1'b1);
    endf(4095, 7, 8, 1, 1);
    spl = -1;

    // vsync returns after 5 lines
    start(); frame(5, 1'b1);
    endf(5 * HOR, 5, 5, 1, 1);

    // back-pressure: 2 pixel times on line 1, 3 pixel times on line 4
    rlo[1] = 10; rlen[1] = 4; rlo[4] = 20; rlen[4] = 6;
    start(); frame(8, 1'b1);
    endf(4095, 8, 8, 1, 1);
    rlen[1] = 0; rlen[4] = 0;

    // odd byte count on line 2
    spl = 2; spbytes = 2 * HOR + 1;
    start(); frame(8, 1'b1);
    endf(4096, 8, 8, 1, 1);
    spl = -1;

    // random data and random ready
    g_rnd_data = 1'b1; g_rnd_rdy = 1'b1;
    start(); frame(8, 1'b1);
    endf(4096 - m_drop, -1, 8, (m_drop > 0) ? 1 : 0, 1);
    g_rnd_rdy = 1'b0;

    // reset mid-capture, then a clean re-armed frame
    rst_line = 2; rst_at = 301;
    start(); frame(8, 1'b1);
    endf(-1, -1, 0, 0, 0);
    rst_line = -1;
    start(); frame(8, 1'b1);
    endf(4096, 8, 8, 0, 1);
    chk("rearm_sof", rx_sof, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cmos_capture_ctrl.md
# cmos_capture_ctrl

Frame-capture sequencer between the CMOS camera byte interface and the SDRAM write path. On request it waits for a clean frame boundary, then packs byte pairs into 16-bit RGB565 pixels for exactly one frame of `VER_NUM` lines × `HOR_NUM` pixels. Pixels are delivered over a valid/ready stream with start-of-frame and end-of-line markers. Size mismatches and back-pressure overflow are flagged, and it runs in the camera pixel-clock domain.

## Interface
- `HOR_NUM`, 512: pixels (byte pairs) per line
- `VER_NUM`, 8: lines per captured frame
- `CNT_W`, 16: width of pixel/line counters
- `cmos_pclk`  in  1  camera pixel clock, sole clock
- `rst`  in  1  asynchronous, active-high reset
- `cap_start`  in  1  one-cycle request to capture one frame; ignored while `cap_busy`
- `cap_busy`  out  1  high from accepted `cap_start` until the `cap_done` cycle, inclusive
- `cap_done`  out  1  one-cycle pulse: frame finished (ok or error)
- `cap_err`  out  1  sticky error; cleared on accepted `cap_start`
- `cmos_data`  in  8  camera byte
- `cmos_href`  in  1  line-valid
- `cmos_vsyn`  in  1  frame blanking, high between frames
- `pix_data`  out  16  packed pixel {first byte, second byte}
- `pix_valid`  out  1  pixel available
- `pix_ready`  in  1  downstream accepts when high with `pix_valid`
- `pix_sof`  out  1  qualifies first pixel of frame
- `pix_eol`  out  1  qualifies last pixel of each line
- `line_cnt`  out  CNT_W  lines completed in current capture

## Operation
- All camera inputs are registered once (`*_q`) before use; edge detection uses `*_q` and a second delayed copy.
- FSM states and transitions:
  - IDLE → ARM on `cap_start`.
  - ARM → WAIT_SOF on `cmos_vsyn_q`=1.
  - WAIT_SOF → CAPTURE on `cmos_vsyn_q` falling edge.
  - CAPTURE → DONE when `line_cnt` reaches `VER_NUM`, or on `cmos_vsyn_q` rising edge (early end, sets error).
  - DONE → IDLE after one cycle. `cap_done`=1 only in DONE.
- Because ARM waits for `cmos_vsyn_q` high, a request issued mid-frame never captures a partial frame.
- Packing in CAPTURE while `cmos_href_q`=1:
  - A byte toggle starts at 0 at each href rise.
  - Toggle 0: byte latched as `[15:8]`.
  - Toggle 1: byte forms `[7:0]`, and the pixel is pushed to the output buffer.
- A per-line pixel counter increments on each push and clears at href fall.
- At href fall:
  - If pixel count ≠ `HOR_NUM`, or the toggle is 1 (odd byte count, dangling byte discarded), set `cap_err`.
  - `line_cnt` increments. The line still counts toward `VER_NUM`.
- `pix_eol` is tagged on push number `HOR_NUM` of a line. `pix_sof` is tagged on the first push after entering CAPTURE.
- Pixel counter saturates at all-ones. Pushes beyond `HOR_NUM` in a line are still forwarded, and `cap_err` is set at line end.
- The output buffer is 2 entries deep.
  - Push while full with no pop in the same cycle: pixel dropped, `cap_err` set.
  - Push while full with a simultaneous pop is accepted.
- Href activity outside CAPTURE is ignored; no pushes occur.
- `cap_start` in DONE is ignored.

## Timing
- Reset values: state IDLE, `cap_busy`=0, `cap_done`=0, `cap_err`=0, `pix_valid`=0, `pix_data`=0, `pix_sof`=0, `pix_eol`=0, `line_cnt`=0, buffer empty.
- Latency: low byte on pins in cycle n → `pix_valid`=1 in cycle n+2 when the buffer is empty.
- `pix_data`, `pix_sof` and `pix_eol` are stable while `pix_valid`=1 and `pix_ready`=0.
- `cap_done` asserts no earlier than the cycle after the final pixel's push. The buffer may still hold up to 2 pixels; the downstream drains them.
- `rst` mid-capture: immediate return to reset values, buffer flushed, no `cap_done`.

## Structure
- Shared package `cam_pkg`: FSM state enum (IDLE, ARM, WAIT_SOF, CAPTURE, DONE), RGB565 pixel typedef, default `HOR_NUM`/`VER_NUM` constants.
- Sub-module `pix_fifo2`: 2-entry FIFO carrying {sof, eol, data[15:0]}, with push, pop, full, empty and the simultaneous push/pop-when-full rule.

## Test plan
- Nominal: drive the 512×8 generator pattern with `pix_ready`=1, `cap_start` during vsyn low.
  - Expected: capture begins at the next frame, 4096 pixels, first 0x8000 with `pix_sof`, 8 `pix_eol`.
  - Expected: `line_cnt`=8, one `cap_done`, `cap_err`=0.
- Short line: line 3 has 511 pixels → `cap_err`=1 after its href fall, capture continues, `cap_done` after line 8.
- Early vsync: `cmos_vsyn` rises after 5 lines → DONE, `cap_err`=1, `line_cnt`=5.
- Back-pressure: hold `pix_ready`=0 for 2 pixel times → no loss. Hold it for 3 pixel times → the 3rd pixel is dropped and `cap_err`=1.
- Odd bytes: line with 1025 bytes → 512 pixels, dangling byte discarded, `cap_err`=1.
- Reset and re-arm:
  - Assert `rst` mid-CAPTURE → all outputs at reset values within the same cycle.
  - Then `cap_start` → clean capture of the next frame with `cap_err`=0.
